// File: rtl/mul_pipe_pkg.sv
// Shared width helper and signed range constants for the mul_pipe multiplier pipeline.
package mul_pipe_pkg;

  // Wide enough to hold any product/result range constant the pipeline compares against.
  localparam int RANGE_W = 128;

  typedef enum logic [1:0] {
    RANGE_OK = 2'd0,
    RANGE_HI = 2'd1,
    RANGE_LO = 2'd2
  } range_e;

  function automatic int PROD_WIDTH(input int a, input int b);
    return a + b;
  endfunction

  // Largest value representable in w bits signed: 2^(w-1)-1
  function automatic logic signed [RANGE_W-1:0] smax(input int w);
    return (RANGE_W'(1) << (w - 1)) - RANGE_W'(1);
  endfunction

  // Smallest value representable in w bits signed: -2^(w-1)
  function automatic logic signed [RANGE_W-1:0] smin(input int w);
    logic signed [RANGE_W-1:0] r;
    r = '1;
    return r << (w - 1);
  endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One ready/valid pipeline register: loads when empty or when its successor advances.
module mul_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  output logic         up_ready,
  output logic         dn_valid,
  output logic [W-1:0] dn_data,
  input  logic         dn_ready
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign up_ready = !valid_reg || dn_ready;
  assign dn_valid = valid_reg;
  assign dn_data  = data_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (up_ready) begin
      valid_reg <= up_valid;
      if (up_valid) data_reg <= up_data;
    end
  end

endmodule

// File: rtl/mul_pipe_hs.sv
// mul_pipe_hs: NUM_STAGE-deep ready/valid signed multiplier with overflow flag.
// Define MUL_SAT_EN to saturate dout on overflow instead of wrapping.
module mul_pipe_hs
  import mul_pipe_pkg::*;
#(
  parameter int din0_WIDTH = 11,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 11,
  parameter int NUM_STAGE  = 3
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PW = PROD_WIDTH(din0_WIDTH, din1_WIDTH);
  localparam int RW = dout_WIDTH + 1;
  localparam logic signed [RANGE_W-1:0] OUT_MAX = smax(dout_WIDTH);
  localparam logic signed [RANGE_W-1:0] OUT_MIN = smin(dout_WIDTH);

  logic                 run_reg;
  logic signed [PW-1:0] stage_data  [NUM_STAGE];
  logic                 stage_valid [NUM_STAGE+1];
  logic                 stage_ready [NUM_STAGE+1];
  logic [RW-1:0]        res_data;

  // Holds in_ready low through reset and for the reset edge itself.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) run_reg <= 1'b0;
    else           run_reg <= 1'b1;
  end

  assign stage_valid[0]         = in_valid && run_reg;
  assign stage_data[0]          = PW'(din0) * PW'(din1);
  assign stage_ready[NUM_STAGE] = out_ready;
  assign in_ready               = run_reg && stage_ready[0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      if (gi < NUM_STAGE - 1) begin : g_mid
        mul_pipe_stage #(.W(PW)) u_stage (
          .clk      (ap_clk),
          .rst_n    (ap_rst_n),
          .up_valid (stage_valid[gi]),
          .up_data  (stage_data[gi]),
          .up_ready (stage_ready[gi]),
          .dn_valid (stage_valid[gi+1]),
          .dn_data  (stage_data[gi+1]),
          .dn_ready (stage_ready[gi+1])
        );
      end else begin : g_last
        logic signed [RANGE_W-1:0] p_ext;
        range_e                    rng;
        logic [dout_WIDTH-1:0]     res_val;
        logic [RW-1:0]             res_next;

        always_comb begin
          p_ext = RANGE_W'(stage_data[gi]);
          rng   = RANGE_OK;
          if (p_ext > OUT_MAX)      rng = RANGE_HI;
          else if (p_ext < OUT_MIN) rng = RANGE_LO;
`ifdef MUL_SAT_EN
          case (rng)
            RANGE_HI: res_val = OUT_MAX[dout_WIDTH-1:0];
            RANGE_LO: res_val = OUT_MIN[dout_WIDTH-1:0];
            default:  res_val = stage_data[gi][dout_WIDTH-1:0];
          endcase
`else
          res_val = stage_data[gi][dout_WIDTH-1:0];
`endif
          res_next = {rng != RANGE_OK, res_val};
        end

        // Result register doubles as the output register, so dout/ovf hold under stall.
        mul_pipe_stage #(.W(RW)) u_stage (
          .clk      (ap_clk),
          .rst_n    (ap_rst_n),
          .up_valid (stage_valid[gi]),
          .up_data  (res_next),
          .up_ready (stage_ready[gi]),
          .dn_valid (stage_valid[gi+1]),
          .dn_data  (res_data),
          .dn_ready (stage_ready[gi+1])
        );
      end
    end
  endgenerate

  assign out_valid = stage_valid[NUM_STAGE];
  assign dout      = res_data[dout_WIDTH-1:0];
  assign ovf       = res_data[RW-1];

endmodule

// File: tb/tb_mul_pipe_hs.sv
// Scoreboard bench for mul_pipe_hs: default 3-stage instance plus a 1-stage 16x16->32 instance.
module tb_mul_pipe_hs;

  localparam int S_A = 3;
  localparam int S_B = 1;
`ifdef MUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    longint d;
    bit     o;
    int     cyc;
    bit     timed;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic               a_in_valid = 1'b0;
  logic               a_in_ready;
  logic signed [10:0] a_din0 = '0;
  logic signed [3:0]  a_din1 = '0;
  logic               a_out_valid;
  logic               a_out_ready = 1'b0;
  logic [10:0]        a_dout;
  logic               a_ovf;
  bit                 a_timed = 1'b0;
  exp_t               a_q[$];
  int                 a_pushes = 0;
  int                 a_pops = 0;

  logic               b_in_valid = 1'b0;
  logic               b_in_ready;
  logic signed [15:0] b_din0 = '0;
  logic signed [15:0] b_din1 = '0;
  logic               b_out_valid;
  logic               b_out_ready = 1'b1;
  logic [31:0]        b_dout;
  logic               b_ovf;
  exp_t               b_q[$];

  mul_pipe_hs u_dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .din0(a_din0), .din1(a_din1),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .dout(a_dout), .ovf(a_ovf)
  );

  mul_pipe_hs #(.din0_WIDTH(16), .din1_WIDTH(16), .dout_WIDTH(32), .NUM_STAGE(1)) u_dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .din0(b_din0), .din1(b_din1),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .dout(b_dout), .ovf(b_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: exact product, range test against dw-bit signed limits, wrap or saturate.
  function automatic void model(input longint a, input longint b, input int dw,
                                output longint d, output bit o);
    longint p, mx, mn, r;
    p  = a * b;
    mx = (longint'(1) << (dw - 1)) - 1;
    mn = -mx - 1;
    o  = (p > mx) || (p < mn);
    r  = p;
    if (SAT && p > mx)      r = mx;
    else if (SAT && p < mn) r = mn;
    d  = r & ((longint'(1) << dw) - 1);
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      a_q.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) check("a_spurious_out_valid", longint'(a_out_valid), 0);
        else begin
          exp_t e;
          e = a_q.pop_front();
          a_pops++;
          check("a_dout", longint'(a_dout), e.d);
          check("a_ovf", longint'(a_ovf), longint'(e.o));
          if (e.timed) check("a_latency", longint'(cyc - e.cyc), S_A);
        end
      end
      if (a_in_valid && a_in_ready) begin
        exp_t e;
        model(a_din0, a_din1, 11, e.d, e.o);
        e.cyc = cyc;
        e.timed = a_timed;
        a_q.push_back(e);
        a_pushes++;
        $display("A accept din0=%0d din1=%0d exp_dout=0x%0h exp_ovf=%0d", a_din0, a_din1, e.d, e.o);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_q.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) check("b_spurious_out_valid", longint'(b_out_valid), 0);
        else begin
          exp_t e;
          e = b_q.pop_front();
          check("b_dout", longint'(b_dout), e.d);
          check("b_ovf", longint'(b_ovf), longint'(e.o));
          check("b_latency", longint'(cyc - e.cyc), S_B);
        end
      end
      if (b_in_valid && b_in_ready) begin
        exp_t e;
        model(b_din0, b_din1, 32, e.d, e.o);
        e.cyc = cyc;
        e.timed = 1'b1;
        b_q.push_back(e);
        $display("B accept din0=%0d din1=%0d exp_dout=%0d exp_ovf=%0d", b_din0, b_din1, e.d, e.o);
      end
    end
  end

  // Drives one pair starting just after a rising edge; returns just after the accepting edge.
  task automatic send_a(input longint a, input longint b, input bit timed);
    bit acc;
    int n;
    a_din0 = 11'(a);
    a_din1 = 4'(b);
    a_timed = timed;
    a_in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("a_accept_timeout", longint'(acc), 1);
    a_in_valid = 1'b0;
  endtask

  task automatic drain_a();
    int n;
    n = 0;
    while (a_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("a_drain_left", longint'(a_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", longint'(a_in_ready), 0);
    check("rst_out_valid", longint'(a_out_valid), 0);
    check("rst_dout", longint'(a_dout), 0);
    check("rst_ovf", longint'(a_ovf), 0);
    check("rst_b_out_valid", longint'(b_out_valid), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_rst", longint'(a_in_ready), 1);
    @(posedge clk);
    #1 a_out_ready = 1'b1;

    // Directed values with free-flowing output: latency must be exactly S_A.
    send_a(100, 3, 1'b1);
    send_a(-5, 7, 1'b1);
    send_a(-1024, -8, 1'b1);
    send_a(341, 3, 1'b1);
    send_a(-256, 4, 1'b1);
    send_a(-128, -8, 1'b1);
    send_a(1023, 7, 1'b1);
    drain_a();

    // Ten back-to-back pairs with the output stalled for cycles 2-6.
    fork
      begin
        for (int i = 0; i < 10; i++) send_a(i * 200 - 1000, i - 5, 1'b0);
      end
      begin
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", longint'(a_in_ready), 0);
        check("stall_out_valid", longint'(a_out_valid), 1);
        check("stall_hold_dout", longint'(a_dout), a_q[0].d);
        @(posedge clk);
        @(negedge clk);
        check("stall_hold_dout2", longint'(a_dout), a_q[0].d);
        check("stall_hold_ovf", longint'(a_ovf), longint'(a_q[0].o));
        @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join
    drain_a();
    check("a_pops_eq_pushes", longint'(a_pops), longint'(a_pushes));

    // Reset with two results in flight: both must vanish.
    send_a(50, 2, 1'b0);
    send_a(-60, 3, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", longint'(a_out_valid), 0);
    check("midrst_dout", longint'(a_dout), 0);
    check("midrst_in_ready", longint'(a_in_ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_no_stale", longint'(a_out_valid), 0);
    end
    @(posedge clk);
    #1;
    send_a(7, -7, 1'b1);
    drain_a();

    // Single-stage 16x16 -> 32 instance.
    b_din0 = -16'sd32768;
    b_din1 = -16'sd32768;
    b_in_valid = 1'b1;
    @(negedge clk);
    check("b_in_ready", longint'(b_in_ready), 1);
    @(posedge clk);
    #1;
    b_din0 = 16'sd32767;
    b_din1 = -16'sd32768;
    @(negedge clk);
    check("b_in_ready2", longint'(b_in_ready), 1);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    n = 0;
    while (b_q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("b_drain_left", longint'(b_q.size()), 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
